// File: rtl/mult_parity_core_if.sv
// Request/result bundle between a mult initiator (master) and the multiplier core (slave).
// Single clock domain; req is held until ack, ack and result_rdy are one-cycle strobes.
interface mult_parity_core_if #(
    parameter int DATA_W = 16
);
    logic                  req;
    logic [DATA_W-1:0]     arg_a;
    logic                  arg_a_parity;
    logic [DATA_W-1:0]     arg_b;
    logic                  arg_b_parity;
    logic                  ack;
    logic [2*DATA_W-1:0]   result;
    logic                  result_parity;
    logic                  arg_parity_error;
    logic                  result_rdy;

    modport master (
        output req, arg_a, arg_a_parity, arg_b, arg_b_parity,
        input  ack, result, result_parity, arg_parity_error, result_rdy
    );

    modport slave (
        input  req, arg_a, arg_a_parity, arg_b, arg_b_parity,
        output ack, result, result_parity, arg_parity_error, result_rdy
    );
endinterface

// File: rtl/mult_parity_core.sv
// Iterative signed shift-add multiplier with operand parity check; ack at N+1, result_rdy at N+DATA_W+1 (N+1 on parity error).
// No backpressure: req is only sampled in IDLE and is neither queued nor acknowledged while busy.
module mult_parity_core #(
    parameter int DATA_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    mult_parity_core_if.slave   bus
);
    localparam int RES_W = 2 * DATA_W;
    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t             state;
    logic [DATA_W-1:0]  a_mag;
    logic [DATA_W-1:0]  b_mag;
    logic               sign;
    logic [CNT_W-1:0]   cnt;
    logic [RES_W-1:0]   acc;

    logic [DATA_W-1:0]  a_mag_in;
    logic [DATA_W-1:0]  b_mag_in;
    logic               par_err;
    logic [RES_W-1:0]   acc_nxt;
    logic [RES_W-1:0]   prod;

    // Unsigned DATA_W-bit magnitude still holds |-2^(DATA_W-1)| exactly.
    always_comb begin
        a_mag_in = bus.arg_a[DATA_W-1] ? -bus.arg_a : bus.arg_a;
        b_mag_in = bus.arg_b[DATA_W-1] ? -bus.arg_b : bus.arg_b;
        par_err  = ((^bus.arg_a) != bus.arg_a_parity) || ((^bus.arg_b) != bus.arg_b_parity);
        acc_nxt  = b_mag[cnt] ? acc + ({{DATA_W{1'b0}}, a_mag} << cnt) : acc;
        prod     = (sign && (acc_nxt != '0)) ? -acc_nxt : acc_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state                <= IDLE;
            a_mag                <= '0;
            b_mag                <= '0;
            sign                 <= 1'b0;
            cnt                  <= '0;
            acc                  <= '0;
            bus.ack              <= 1'b0;
            bus.result           <= '0;
            bus.result_parity    <= 1'b0;
            bus.arg_parity_error <= 1'b0;
            bus.result_rdy       <= 1'b0;
        end else begin
            bus.ack        <= 1'b0;
            bus.result_rdy <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req) begin
                        bus.ack <= 1'b1;
                        a_mag   <= a_mag_in;
                        b_mag   <= b_mag_in;
                        sign    <= bus.arg_a[DATA_W-1] ^ bus.arg_b[DATA_W-1];
                        cnt     <= '0;
                        acc     <= '0;
                        if (par_err) begin
                            bus.result           <= '0;
                            bus.result_parity    <= 1'b0;
                            bus.arg_parity_error <= 1'b1;
                            bus.result_rdy       <= 1'b1;
                            state                <= DONE;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    acc <= acc_nxt;
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_LAST) begin
                        bus.result           <= prod;
                        bus.result_parity    <= ^prod;
                        bus.arg_parity_error <= 1'b0;
                        bus.result_rdy       <= 1'b1;
                        state                <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_parity_core.sv
// Directed plus random stimulus for mult_parity_core, checked against a plain-arithmetic product model.
module tb_mult_parity_core;
    localparam int W   = 16;
    localparam int LAT = W + 1;

    logic clk = 1'b0;
    logic rst;
    int   compared = 0;
    int   mism     = 0;

    always #5 clk = ~clk;

    mult_parity_core_if #(.DATA_W(W)) mif ();
    mult_parity_core #(.DATA_W(W)) dut (.clk(clk), .rst(rst), .bus(mif));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mism++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic par(input logic [W-1:0] x);
        return ^x;
    endfunction

    function automatic void model(input logic [W-1:0] a, input logic pa,
                                  input logic [W-1:0] b, input logic pb,
                                  output logic [2*W-1:0] res, output logic err);
        int p;
        err = (pa != par(a)) || (pb != par(b));
        p   = int'($signed(a)) * int'($signed(b));
        res = err ? '0 : p;
    endfunction

    task automatic run_op(input logic [W-1:0] a, input logic pa, input logic [W-1:0] b, input logic pb);
        logic [2*W-1:0] er;
        logic           ee;
        int             lat;
        int             extra;
        model(a, pa, b, pb, er, ee);
        mif.arg_a = a; mif.arg_a_parity = pa;
        mif.arg_b = b; mif.arg_b_parity = pb;
        mif.req   = 1'b1;
        step();
        chk("ack", mif.ack, 1);
        chk("rdy_at_ack", mif.result_rdy, ee);
        mif.req   = 1'b0;
        mif.arg_a = 16'($urandom); mif.arg_b = 16'($urandom);
        mif.arg_a_parity = 1'($urandom); mif.arg_b_parity = 1'($urandom);
        lat = 1; extra = 0;
        while (!mif.result_rdy && lat < 40) begin
            step();
            lat++;
            if (mif.ack) extra++;
        end
        chk("latency", lat, ee ? 1 : LAT);
        chk("no_ack_busy", extra, 0);
        chk("result", mif.result, er);
        chk("result_parity", mif.result_parity, ^er);
        chk("arg_parity_error", mif.arg_parity_error, ee);
        step();
        chk("rdy_pulse", mif.result_rdy, 0);
        chk("ack_pulse", mif.ack, 0);
    endtask

    initial begin
        logic [W-1:0]   a, b;
        logic           pa, pb;
        logic [2*W-1:0] e1, e2;
        logic           dummy;
        logic [2*W-1:0] q_exp[$];
        int             ack_t[$];
        int             rdy_cnt;
        int             seen;
        int             r;

        rst = 1'b1;
        mif.req = 1'b0;
        mif.arg_a = '0; mif.arg_b = '0;
        mif.arg_a_parity = 1'b0; mif.arg_b_parity = 1'b0;
        step(); step();
        chk("rst_ack", mif.ack, 0);
        chk("rst_rdy", mif.result_rdy, 0);
        chk("rst_result", mif.result, 0);
        chk("rst_parity", mif.result_parity, 0);
        chk("rst_err", mif.arg_parity_error, 0);

        // rst and req together: rst wins
        mif.arg_a = 16'd5; mif.arg_a_parity = par(16'd5);
        mif.arg_b = 16'd9; mif.arg_b_parity = par(16'd9);
        mif.req = 1'b1;
        step();
        chk("rst_req_no_ack", mif.ack, 0);
        rst = 1'b0; mif.req = 1'b0;
        step();
        chk("idle_no_ack", mif.ack, 0);

        run_op(16'd3, 1'b0, 16'hFFFB, par(16'hFFFB));
        chk("tp_3x-5", mif.result, 32'hFFFFFFF1);
        chk("tp_3x-5_par", mif.result_parity, 1);
        run_op(16'h8000, 1'b1, 16'h8000, 1'b1);
        chk("tp_min_sq", mif.result, 32'h40000000);
        run_op(16'h7FFF, 1'b1, 16'h8000, 1'b1);
        chk("tp_max_x_min", mif.result, 32'hC0008000);
        chk("tp_max_x_min_par", mif.result_parity, 1);
        run_op(16'd3, 1'b1, 16'hFFFB, par(16'hFFFB));
        chk("tp_err_a", mif.arg_parity_error, 1);
        run_op(16'd3, 1'b0, 16'hFFFB, ~par(16'hFFFB));
        chk("tp_err_b", mif.arg_parity_error, 1);
        run_op(16'd3, 1'b1, 16'hFFFB, ~par(16'hFFFB));
        chk("tp_err_ab_result", mif.result, 0);
        run_op(16'd0, 1'b0, 16'hFFFF, par(16'hFFFF));
        chk("tp_zero", mif.result, 0);
        chk("tp_zero_par", mif.result_parity, 0);

        // Back-to-back: req held across two valid operations
        model(16'd123, par(16'd123), 16'hFE38, par(16'hFE38), e1, dummy);
        model(16'hFFF9, par(16'hFFF9), 16'd999, par(16'd999), e2, dummy);
        q_exp.push_back(e1);
        q_exp.push_back(e2);
        mif.arg_a = 16'd123; mif.arg_a_parity = par(16'd123);
        mif.arg_b = 16'hFE38; mif.arg_b_parity = par(16'hFE38);
        mif.req = 1'b1;
        rdy_cnt = 0;
        for (int c = 1; c <= 45; c++) begin
            step();
            if (mif.ack) begin
                ack_t.push_back(c);
                if (ack_t.size() == 1) begin
                    mif.arg_a = 16'hFFF9; mif.arg_a_parity = par(16'hFFF9);
                    mif.arg_b = 16'd999;  mif.arg_b_parity = par(16'd999);
                end else begin
                    mif.req = 1'b0;
                    mif.arg_a = 16'($urandom); mif.arg_b = 16'($urandom);
                end
            end
            if (mif.result_rdy) begin
                rdy_cnt++;
                chk("b2b_result", mif.result, (q_exp.size() > 0) ? q_exp.pop_front() : 32'hDEADBEEF);
            end
        end
        mif.req = 1'b0;
        chk("b2b_acks", ack_t.size(), 2);
        chk("b2b_spacing", (ack_t.size() == 2) ? ack_t[1] - ack_t[0] : -1, 18);
        chk("b2b_rdys", rdy_cnt, 2);

        // Reset in the middle of CALC
        mif.arg_a = 16'd1000; mif.arg_a_parity = par(16'd1000);
        mif.arg_b = 16'hFFFD; mif.arg_b_parity = par(16'hFFFD);
        mif.req = 1'b1;
        step();
        chk("abort_ack", mif.ack, 1);
        mif.req = 1'b0;
        repeat (6) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_result", mif.result, 0);
        chk("abort_parity", mif.result_parity, 0);
        chk("abort_err", mif.arg_parity_error, 0);
        chk("abort_rdy", mif.result_rdy, 0);
        seen = 0;
        repeat (25) begin
            step();
            if (mif.result_rdy) seen++;
        end
        chk("abort_no_rdy", seen, 0);
        run_op(16'd7, par(16'd7), 16'd6, par(16'd6));
        chk("post_abort_42", mif.result, 32'd42);
        chk("post_abort_par", mif.result_parity, 1);

        repeat (25) begin
            a  = 16'($urandom);
            b  = 16'($urandom);
            pa = par(a);
            pb = par(b);
            r  = $urandom_range(0, 9);
            if (r == 0) pa = ~pa;
            if (r == 1) pb = ~pb;
            run_op(a, pa, b, pb);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
        $finish;
    end
endmodule
